qspi_flash_resp: RTL and testbench

FPGA-side SPI/QSPI NOR-flash responder: the device end of the SoC's QSPI0 master port (sck, cs, dq[3:0]). It lets the e203 SoC boot and execute in place from on-chip block RAM instead of an external flash part. The block oversamples the master's pins on a fast system clock, decodes a small flash command set, and fetches bytes from a synchronous ROM/BRAM read port. It sits in the FPGA top, between the QSPI0 pad wires and a preloaded BRAM.

---
 rtl/qspi_flash_resp_pkg.sv | 14 +
 rtl/qspi_resp_sync.sv | 38 +++
 rtl/qspi_flash_resp.sv | 211 +++++++++++++++++++++
 tb/tb_qspi_flash_resp.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/qspi_flash_resp_pkg.sv
// qspi_flash_resp_pkg: opcodes, FSM encoding, counter widths and ID byte select for the QSPI flash responder
package qspi_flash_resp_pkg;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_QUAD_READ = 8'h6B;
  localparam logic [7:0] OP_JEDEC_ID  = 8'h9F;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam int CNT_W = 8;
  localparam int BIT_W = 3;
  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_IGNORE} state_e;
  function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
    return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : idx == 2'd2 ? id[7:0] : 8'h00;
  endfunction
endpackage

// File: rtl/qspi_resp_sync.sv
// qspi_resp_sync: 2-flop synchronizers for the QSPI pins plus sck/cs edge pulses
module qspi_resp_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       cs,
  input  logic [3:0] dq,
  output logic [3:0] dq_s,
  output logic       sck_rise,
  output logic       sck_fall,
  output logic       cs_rise,
  output logic       cs_fall
);
  localparam logic [5:0] IDLE_PINS = 6'b010000;
  logic [5:0] s1_q, s1_d, s2_q, s2_d;
  logic [1:0] prev_q, prev_d;
  always_comb begin
    s1_d = {sck, cs, dq};
    s2_d = s1_q;
    prev_d = s2_q[5:4];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= IDLE_PINS;
      s2_q <= IDLE_PINS;
      prev_q <= 2'b01;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      prev_q <= prev_d;
    end
  end
  assign dq_s = s2_q[3:0];
  assign sck_rise = s2_q[5] & ~prev_q[1];
  assign sck_fall = ~s2_q[5] & prev_q[1];
  assign cs_rise = s2_q[4] & ~prev_q[0];
  assign cs_fall = ~s2_q[4] & prev_q[0];
endmodule

// File: rtl/qspi_flash_resp.sv
// qspi_flash_resp: QSPI NOR-flash responder serving reads, JEDEC ID and RDSR from a synchronous BRAM port.
// Define QSPI_FLASH_RESP_QUAD_EN to add the 0x6B quad output read.
module qspi_flash_resp
  import qspi_flash_resp_pkg::*;
#(
  parameter int unsigned ADDR_W     = 24,
  parameter logic [23:0] JEDEC_ID   = 24'hEF4017,
  parameter int unsigned DUMMY_CLKS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              qspi_sck,
  input  logic              qspi_cs,
  input  logic [3:0]        qspi_dq_i,
  output logic [3:0]        qspi_dq_o,
  output logic [3:0]        qspi_dq_oe,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              busy,
  output logic              cmd_err
);
`ifdef QSPI_FLASH_RESP_QUAD_EN
  localparam logic [3:0] PIN_MASK = 4'hF;
`else
  localparam logic [3:0] PIN_MASK = 4'h2;
`endif
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic [3:0] dq_s;
  logic unused_dq;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [23:0] sr_q, sr_d, shift_in;
  logic [7:0] op_q, op_d, tx_q, tx_d, pre_q, pre_d;
  logic [1:0] id_idx_q, id_idx_d, ld_q, ld_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic rvalid_q, rvalid_d, mem_req_q, mem_req_d, cmd_err_q, cmd_err_d;
  logic [3:0] dq_o_q, dq_o_d, oe_q, oe_d;
  logic quad, mem_src, load;

  qspi_resp_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .sck      (qspi_sck),
    .cs       (qspi_cs),
    .dq       (qspi_dq_i),
    .dq_s     (dq_s),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_rise  (cs_rise),
    .cs_fall  (cs_fall)
  );

  assign unused_dq = ^dq_s[3:1];
  assign shift_in = {sr_q[22:0], dq_s[0]};
  assign mem_src = op_q != OP_JEDEC_ID && op_q != OP_RDSR;
`ifdef QSPI_FLASH_RESP_QUAD_EN
  assign quad = op_q == OP_QUAD_READ;
`else
  assign quad = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    sr_d = sr_q;
    op_d = op_q;
    id_idx_d = id_idx_q;
    tx_d = tx_q;
    bit_d = bit_q;
    ld_d = {ld_q[0], 1'b0};
    mem_req_d = 1'b0;
    mem_addr_d = mem_addr_q;
    cmd_err_d = 1'b0;
    dq_o_d = dq_o_q;
    oe_d = oe_q;
    rvalid_d = mem_req_q;
    pre_d = rvalid_q ? mem_rdata : pre_q;
    load = 1'b0;
    if (cs_rise) begin
      state_d = ST_IDLE;
      oe_d = 4'h0;
      dq_o_d = 4'h0;
      ld_d = 2'b00;
    end else begin
      unique case (state_q)
        ST_IDLE: if (cs_fall) begin
          state_d = ST_CMD;
          cnt_d = '0;
        end
        ST_CMD: if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          sr_d = shift_in;
          if (cnt_q == CNT_W'(7)) begin
            op_d = shift_in[7:0];
            cnt_d = '0;
            bit_d = '0;
            unique case (shift_in[7:0])
              OP_READ, OP_FAST_READ: state_d = ST_ADDR;
`ifdef QSPI_FLASH_RESP_QUAD_EN
              OP_QUAD_READ: state_d = ST_ADDR;
`endif
              OP_JEDEC_ID: begin
                state_d = ST_DATA;
                id_idx_d = 2'd0;
                ld_d = 2'b01;
              end
              OP_RDSR: begin
                state_d = ST_DATA;
                id_idx_d = 2'd3;
                ld_d = 2'b01;
              end
              default: begin
                state_d = ST_IGNORE;
                cmd_err_d = 1'b1;
              end
            endcase
          end
        end
        ST_ADDR: if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          sr_d = shift_in;
          if (cnt_q == CNT_W'(23)) begin
            cnt_d = '0;
            mem_req_d = 1'b1;
            mem_addr_d = shift_in[ADDR_W-1:0];
            if (op_q == OP_READ || DUMMY_CLKS == 0) begin
              state_d = ST_DATA;
              ld_d = 2'b01;
            end else state_d = ST_DUMMY;
          end
        end
        ST_DUMMY: if (sck_rise) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DUMMY_CLKS - 1)) begin
            state_d = ST_DATA;
            ld_d = 2'b01;
          end
        end
        ST_DATA: begin
          load = ld_q[1];
          if (sck_fall) begin
            dq_o_d = quad ? tx_q[7:4] : {2'b00, tx_q[7], 1'b0};
            oe_d = quad ? 4'hF : 4'h2;
            tx_d = quad ? {tx_q[3:0], 4'h0} : {tx_q[6:0], 1'b0};
            bit_d = bit_q + 1'b1;
            if (bit_q == (quad ? BIT_W'(1) : BIT_W'(7))) begin
              load = 1'b1;
              bit_d = '0;
            end
          end
        end
        ST_IGNORE: ;
        default: state_d = ST_IDLE;
      endcase
    end
    // A load consumes the prefetched (or just-returned) byte and requests the next one
    if (load) begin
      tx_d = mem_src ? (rvalid_q ? mem_rdata : pre_q) : id_byte(JEDEC_ID, id_idx_q);
      id_idx_d = id_idx_q + {1'b0, id_idx_q != 2'd3};
      if (mem_src) begin
        mem_req_d = 1'b1;
        mem_addr_d = mem_addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      sr_q <= '0;
      op_q <= '0;
      id_idx_q <= '0;
      tx_q <= '0;
      bit_q <= '0;
      ld_q <= '0;
      mem_req_q <= 1'b0;
      mem_addr_q <= '0;
      cmd_err_q <= 1'b0;
      dq_o_q <= '0;
      oe_q <= '0;
      rvalid_q <= 1'b0;
      pre_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sr_q <= sr_d;
      op_q <= op_d;
      id_idx_q <= id_idx_d;
      tx_q <= tx_d;
      bit_q <= bit_d;
      ld_q <= ld_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      cmd_err_q <= cmd_err_d;
      dq_o_q <= dq_o_d;
      oe_q <= oe_d;
      rvalid_q <= rvalid_d;
      pre_q <= pre_d;
    end
  end

  assign qspi_dq_o = dq_o_q & PIN_MASK;
  assign qspi_dq_oe = oe_q & PIN_MASK;
  assign mem_req = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign cmd_err = cmd_err_q;
  assign busy = state_q != ST_IDLE;
endmodule

// File: tb/tb_qspi_flash_resp.sv
// tb_qspi_flash_resp: directed SPI-master transactions against qspi_flash_resp with a small BRAM model
module tb_qspi_flash_resp;
  localparam int HALF = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic qspi_sck = 1'b0;
  logic qspi_cs = 1'b1;
  logic [3:0] qspi_dq_i = 4'h0;
  logic [3:0] qspi_dq_o, qspi_dq_oe;
  logic mem_req, busy, cmd_err;
  logic [23:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  int n_chk = 0;
  int n_err = 0;
  int req_n = 0;
  int err_cyc = 0;
  logic [23:0] req_addr [0:63];

  always #5 clk = ~clk;

  qspi_flash_resp dut (
    .clk        (clk),
    .reset      (reset),
    .qspi_sck   (qspi_sck),
    .qspi_cs    (qspi_cs),
    .qspi_dq_i  (qspi_dq_i),
    .qspi_dq_o  (qspi_dq_o),
    .qspi_dq_oe (qspi_dq_oe),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .cmd_err    (cmd_err)
  );

  function automatic logic [7:0] bram(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      24'hFFFFFE: return 8'h9A;
      24'hFFFFFF: return 8'hBC;
      24'h000000: return 8'hDE;
      24'h000001: return 8'hF0;
      24'h000010: return 8'hA5;
      24'h000011: return 8'h3C;
      default:    return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  // Read data is only meaningful for the one clk after mem_req
  always @(posedge clk) begin
    mem_rdata <= mem_req ? bram(mem_addr) : 8'hEE;
    if (mem_req && req_n < 64) req_addr[req_n] <= mem_addr;
    if (mem_req) req_n <= req_n + 1;
    if (cmd_err) err_cyc <= err_cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic spi_bit(input logic [3:0] o, output logic [3:0] d, output logic [3:0] e);
    qspi_dq_i = o;
    repeat (HALF) @(negedge clk);
    d = qspi_dq_o;
    e = qspi_dq_oe;
    qspi_sck = 1'b1;
    repeat (HALF) @(negedge clk);
    qspi_sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [3:0] d, e;
    for (int i = 7; i >= 0; i--) spi_bit({3'b000, b[i]}, d, e);
  endtask

  task automatic recv_byte(output logic [7:0] b, output logic [3:0] oe);
    logic [3:0] d, e;
    oe = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(4'h0, d, e);
      b[i] = d[1];
      oe |= e;
    end
  endtask

  task automatic expect_bytes(input string tag, input int n, input logic [63:0] exp);
    logic [7:0] b;
    logic [3:0] oe;
    for (int k = 0; k < n; k++) begin
      recv_byte(b, oe);
      chk($sformatf("%s[%0d]", tag, k), 32'(b), 32'(exp[8*(n-1-k) +: 8]));
      chk($sformatf("%s_oe[%0d]", tag, k), 32'(oe), 32'h2);
    end
  endtask

  task automatic cs_on();
    qspi_cs = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic cs_off();
    repeat (HALF) @(negedge clk);
    qspi_cs = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  initial begin
    logic [7:0] b;
    logic [3:0] oe, d, e;
    int r0, e0;
    repeat (3) @(negedge clk);
    chk("rst_dq_o", 32'(qspi_dq_o), 32'h0);
    chk("rst_dq_oe", 32'(qspi_dq_oe), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_cmd_err", 32'(cmd_err), 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    qspi_cs = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_2clk", 32'(busy), 32'h0);
    @(negedge clk);
    chk("busy_3clk", 32'(busy), 32'h1);
    repeat (HALF - 3) @(negedge clk);
    r0 = req_n;
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    expect_bytes("read", 4, 64'h11223344);
    cs_off();
    for (int k = 0; k < 4; k++) chk($sformatf("read_addr[%0d]", k), 32'(req_addr[r0+k]), 32'h100 + 32'(k));

    cs_on();
    r0 = req_n;
    send_byte(8'h0B); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFE);
    send_byte(8'h00);
    expect_bytes("fast", 4, 64'h9ABCDEF0);
    cs_off();
    chk("fast_addr0", 32'(req_addr[r0]), 32'hFFFFFE);
    chk("fast_addr1", 32'(req_addr[r0+1]), 32'hFFFFFF);
    chk("fast_addr2", 32'(req_addr[r0+2]), 32'h000000);
    chk("fast_addr3", 32'(req_addr[r0+3]), 32'h000001);

    cs_on();
    r0 = req_n;
    send_byte(8'h9F);
    expect_bytes("jedec", 5, 64'hEF40170000);
    cs_off();
    chk("jedec_no_req", 32'(req_n - r0), 32'h0);

    e0 = err_cyc;
    cs_on();
    send_byte(8'hAB);
    recv_byte(b, oe);
    recv_byte(b, d);
    cs_off();
    chk("bad_cmd_err", 32'(err_cyc - e0), 32'h1);
    chk("bad_oe", 32'(oe | d), 32'h0);
    cs_on();
    send_byte(8'h05);
    expect_bytes("rdsr", 2, 64'h0000);
    cs_off();

`ifdef QSPI_FLASH_RESP_QUAD_EN
    cs_on();
    send_byte(8'h6B); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'h00);
    for (int k = 0; k < 4; k++) begin
      spi_bit(4'h0, d, e);
      chk($sformatf("quad_nib[%0d]", k), 32'(d), 32'(k == 0 ? 4'hA : k == 1 ? 4'h5 : k == 2 ? 4'h3 : 4'hC));
      chk($sformatf("quad_oe[%0d]", k), 32'(e), 32'hF);
    end
    cs_off();
`else
    e0 = err_cyc;
    cs_on();
    send_byte(8'h6B); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
    recv_byte(b, oe);
    cs_off();
    chk("noquad_cmd_err", 32'(err_cyc - e0), 32'h1);
    chk("noquad_oe", 32'(oe), 32'h0);
`endif

    cs_on();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
    expect_bytes("abort_b0", 1, 64'h11);
    for (int k = 0; k < 3; k++) spi_bit(4'h0, d, e);
    qspi_cs = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort_oe", 32'(qspi_dq_oe), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    repeat (2 * HALF) @(negedge clk);
    cs_on();
    send_byte(8'h03); send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
    expect_bytes("after_abort", 2, 64'h3344);
    cs_off();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
